ad1_dual_rx: RTL

Dual-channel serial ADC reader for the Pmod AD1 (two AD7476A-class converters sharing SCLK and chip-select). It is the receive-side counterpart of the dual DAC driver in the filter datapath. On request it generates one chip-select and SCLK frame, shifts in 16 bits from each of the two SDATA lines, and presents two 12-bit samples with a single-cycle valid strobe to the FIR/IIR filter input stage.

---
 rtl/ad1_pkg.sv | 26 ++
 rtl/ad1_sclk_gen.sv | 61 ++++++
 rtl/ad1_dual_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ad1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_pkg
//  Description : Shared types and frame constants for the Pmod AD1 dual
//                serial ADC reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad1_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } ad1_state_e;

  // One converter frame: 4 leading zeros followed by 12 unsigned data bits
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_W     = 12;

  // Bit counter must reach FRAME_BITS (16), so 5 bits
  localparam int BITCNT_W   = 5;

endpackage
`default_nettype wire

// File: rtl/ad1_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_sclk_gen
//  Description : SCLK generator for the AD1 reader. While enabled, SCLK
//                toggles every CLK_DIV clk cycles starting high, so the first
//                transition is a fall. Rise/fall strobes are high in the cycle
//                whose closing edge performs the transition. When disabled the
//                counter is cleared and SCLK parks high.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad1_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       wrap;

  assign wrap = en_i && (cnt_q == HP_LAST);

  // Half-period counter and SCLK toggle decision
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  // Counter and SCLK registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap &&  sclk_q;

endmodule
`default_nettype wire

// File: rtl/ad1_dual_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_dual_rx
//  Description : Dual-channel Pmod AD1 serial ADC reader. On start it runs one
//                CS_n/SCLK frame, shifts 16 bits from each SDATA line on SCLK
//                rising edges, then presents two 12-bit samples with a
//                one-cycle valid strobe, followed by a QUIET_CYCLES CS_n-high
//                guard time.
//                Optional feature macro: AD1_FRAME_CHECK_EN - when defined,
//                frame_err reports non-zero leading bits on either channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad1_dual_rx
  import ad1_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              SCLK,
  output logic              CS_n,
  input  logic [1:0]        SDATA,
  output logic              busy,
  output logic [DATA_W-1:0] sample0,
  output logic [DATA_W-1:0] sample1,
  output logic              valid,
  output logic              frame_err
);

  // Without frame checking the leading zeros carry no information, so a
  // DATA_W-wide register suffices: they simply fall off the top.
`ifdef AD1_FRAME_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
`else
  localparam int SHIFT_W = DATA_W;
`endif

  localparam logic [7:0]          QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [BITCNT_W-1:0] BITS_LAST  = BITCNT_W'(FRAME_BITS);

  ad1_state_e          state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]          quiet_q, quiet_d;
  logic [SHIFT_W-1:0]  shift0_q, shift0_d;
  logic [SHIFT_W-1:0]  shift1_q, shift1_d;
  logic [DATA_W-1:0]   sample0_q, sample0_d;
  logic [DATA_W-1:0]   sample1_q, sample1_d;
  logic                valid_q, valid_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
`ifdef AD1_FRAME_CHECK_EN
  logic                ferr_q, ferr_d;
`endif

  logic frame_done;
  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall;

  assign frame_done = (bitcnt_q == BITS_LAST);
  // SCLK stops on the capture of the last bit so it stays parked high
  // through the closing edge, even at CLK_DIV = 1.
  assign sclk_en    = (state_q == SHIFT) && !frame_done;

  ad1_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sclk_en),
    .sclk_o (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // A single half-period wrap can never be both a rise and a fall
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
                                  !(sclk_rise && sclk_fall));

  // Next-state, capture and output-update logic
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    quiet_d   = quiet_q;
    shift0_d  = shift0_q;
    shift1_d  = shift1_q;
    sample0_d = sample0_q;
    sample1_d = sample1_q;
    valid_d   = 1'b0;
`ifdef AD1_FRAME_CHECK_EN
    ferr_d    = ferr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (frame_done) begin
          state_d   = QUIET;
          quiet_d   = '0;
          bitcnt_d  = '0;
          valid_d   = 1'b1;
          sample0_d = shift0_q[DATA_W-1:0];
          sample1_d = shift1_q[DATA_W-1:0];
`ifdef AD1_FRAME_CHECK_EN
          ferr_d    = (|shift0_q[FRAME_BITS-1 -: LEAD_ZEROS]) |
                      (|shift1_q[FRAME_BITS-1 -: LEAD_ZEROS]);
`endif
        end else if (sclk_rise) begin
          shift0_d = {shift0_q[SHIFT_W-2:0], SDATA[0]};
          shift1_d = {shift1_q[SHIFT_W-2:0], SDATA[1]};
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end
      end
      QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = IDLE;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = (state_d != SHIFT);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      quiet_q   <= '0;
      shift0_q  <= '0;
      shift1_q  <= '0;
      sample0_q <= '0;
      sample1_q <= '0;
      valid_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      quiet_q   <= quiet_d;
      shift0_q  <= shift0_d;
      shift1_q  <= shift1_d;
      sample0_q <= sample0_d;
      sample1_q <= sample1_d;
      valid_q   <= valid_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
    end
  end

`ifdef AD1_FRAME_CHECK_EN
  // Leading-zero violation flag, updated only on the valid cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ferr_q <= 1'b0;
    else      ferr_q <= ferr_d;
  end
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign CS_n    = cs_n_q;
  assign busy    = busy_q;
  assign sample0 = sample0_q;
  assign sample1 = sample1_q;
  assign valid   = valid_q;

endmodule
`default_nettype wire
